// File: rtl/exec_pkg.sv
// Shared opcode encodings, FSM state type and decode helper for the
// two-cycle exec unit.
package exec_pkg;

  localparam logic [3:0] OP_LD  = 4'hF;
  localparam logic [3:0] OP_ADD = 4'hD;
  localparam logic [3:0] OP_SUB = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hB;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  function automatic logic op_writes_reg(input logic [3:0] op);
    return (op == OP_LD)  || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/exec_if.sv
// Instruction handshake and result bus between a producer (master) and
// the exec unit (slave).
interface exec_if #(
  parameter int WORD_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 6
);

  logic                     i_flush;
  logic [3:0]               i_opcode;
  logic [OPERAND_WIDTH-1:0] i_operand1;
  logic [OPERAND_WIDTH-1:0] i_operand2;
  logic                     i_inst_valid;
  logic                     o_inst_ack;
  logic                     o_busy;
  logic                     o_flush;
  logic                     o_jump_valid;
  logic [OPERAND_WIDTH-1:0] o_jump_addr;
  logic [WORD_WIDTH-1:0]    o_out;
  logic                     o_carry;

  modport master (
    output i_flush, i_opcode, i_operand1, i_operand2, i_inst_valid,
    input  o_inst_ack, o_busy, o_flush, o_jump_valid, o_jump_addr, o_out, o_carry
  );

  modport slave (
    input  i_flush, i_opcode, i_operand1, i_operand2, i_inst_valid,
    output o_inst_ack, o_busy, o_flush, o_jump_valid, o_jump_addr, o_out, o_carry
  );

endinterface

// File: rtl/exec_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// asynchronous clear; r0 is hardwired to zero.
module exec_regfile
  import exec_pkg::*;
#(
  parameter int WORD_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_a_addr,
  output logic [WORD_WIDTH-1:0]     o_rd_a_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_b_addr,
  output logic [WORD_WIDTH-1:0]     o_rd_b_data,
  input  logic                      i_we,
  input  logic [REG_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WORD_WIDTH-1:0]     i_wr_data
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] rd_arr [NUM_REGS];

  assign rd_arr[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [WORD_WIDTH-1:0] data_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          data_q <= '0;
        end else if (i_we && (i_wr_addr == REG_ADDR_WIDTH'(gi))) begin
          data_q <= i_wr_data;
        end
      end

      assign rd_arr[gi] = data_q;
    end
  endgenerate

  assign o_rd_a_data = rd_arr[i_rd_a_addr];
  assign o_rd_b_data = rd_arr[i_rd_b_addr];

endmodule

// File: rtl/exec_unit.sv
// Two-cycle exec unit: accept and latch an instruction in IDLE, execute the
// latched copy on the following edge, then return to IDLE.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WORD_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int OPERAND_WIDTH  = 6
) (
  input logic  i_clk,
  input logic  i_rst_n,
  exec_if.slave bus
);

  state_e                   state_q, state_d;
  logic [3:0]               opcode_q, opcode_d;
  logic [OPERAND_WIDTH-1:0] op1_q, op1_d;
  logic [OPERAND_WIDTH-1:0] op2_q, op2_d;
  logic                     ack_q, ack_d;
  logic                     jump_valid_q, jump_valid_d;
  logic [OPERAND_WIDTH-1:0] jump_addr_q, jump_addr_d;
  logic [WORD_WIDTH-1:0]    out_q, out_d;
  logic                     carry_q, carry_d;

  logic [REG_ADDR_WIDTH-1:0] ra_idx;
  logic [REG_ADDR_WIDTH-1:0] rb_idx;
  logic [WORD_WIDTH-1:0]     rd_a;
  logic [WORD_WIDTH-1:0]     rd_b;
  logic                      wr_en;
  logic [WORD_WIDTH-1:0]     wr_data;
  logic [WORD_WIDTH:0]       sum_w;
  logic [WORD_WIDTH-1:0]     diff_w;

  // Register indices come from the latched operands, never the live bus.
  assign ra_idx = op1_q[REG_ADDR_WIDTH-1:0];
  assign rb_idx = op2_q[REG_ADDR_WIDTH-1:0];
  assign sum_w  = {1'b0, rd_a} + {1'b0, rd_b};
  assign diff_w = rd_a - rd_b;

  generate
    if (OPERAND_WIDTH > REG_ADDR_WIDTH) begin : g_op1_hi
      logic unused_op1_hi;
      assign unused_op1_hi = ^op1_q[OPERAND_WIDTH-1:REG_ADDR_WIDTH];
    end
  endgenerate

  exec_regfile #(
    .WORD_WIDTH     (WORD_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_a_addr (ra_idx),
    .o_rd_a_data (rd_a),
    .i_rd_b_addr (rb_idx),
    .o_rd_b_data (rd_b),
    .i_we        (wr_en),
    .i_wr_addr   (ra_idx),
    .i_wr_data   (wr_data)
  );

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    ack_d        = 1'b0;
    jump_valid_d = 1'b0;
    jump_addr_d  = jump_addr_q;
    out_d        = out_q;
    carry_d      = carry_q;
    wr_en        = 1'b0;
    wr_data      = rd_a;

    // A flush wins over both acceptance and execution.
    if (bus.i_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_inst_valid) begin
            opcode_d = bus.i_opcode;
            op1_d    = bus.i_operand1;
            op2_d    = bus.i_operand2;
            ack_d    = 1'b1;
            state_d  = ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_d = ST_IDLE;
          wr_en   = op_writes_reg(opcode_q);
          case (opcode_q)
            OP_LD:  wr_data = WORD_WIDTH'(op2_q);
            OP_ADD: begin
              wr_data = sum_w[WORD_WIDTH-1:0];
              carry_d = sum_w[WORD_WIDTH];
            end
            OP_SUB: begin
              wr_data = diff_w;
              carry_d = (rd_a < rd_b);
            end
            OP_AND: wr_data = rd_a & rd_b;
            OP_OR:  wr_data = rd_a | rd_b;
            OP_XOR: wr_data = rd_a ^ rd_b;
            OP_OUT: out_d = rd_a;
            OP_JMP: begin
              jump_valid_d = 1'b1;
              jump_addr_d  = op2_q;
            end
            OP_JZ: begin
              if (rd_a == '0) begin
                jump_valid_d = 1'b1;
                jump_addr_d  = op2_q;
              end
            end
            default: ;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      opcode_q     <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      ack_q        <= 1'b0;
      jump_valid_q <= 1'b0;
      jump_addr_q  <= '0;
      out_q        <= '0;
      carry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      ack_q        <= ack_d;
      jump_valid_q <= jump_valid_d;
      jump_addr_q  <= jump_addr_d;
      out_q        <= out_d;
      carry_q      <= carry_d;
    end
  end

  assign bus.o_inst_ack   = ack_q;
  assign bus.o_busy       = (state_q == ST_EXEC);
  assign bus.o_flush      = bus.i_flush | jump_valid_q;
  assign bus.o_jump_valid = jump_valid_q;
  assign bus.o_jump_addr  = jump_addr_q;
  assign bus.o_out        = out_q;
  assign bus.o_carry      = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: a reference model predicts each
// instruction's visible results, which are compared after its EXEC edge.
module tb_exec_unit;
  import exec_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  exec_if #(.WORD_WIDTH(16), .OPERAND_WIDTH(6)) bus ();

  exec_unit #(
    .WORD_WIDTH     (16),
    .REG_ADDR_WIDTH (4),
    .OPERAND_WIDTH  (6)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] out;
    logic        carry;
    logic        jv;
    logic [5:0]  ja;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] m_regs [16];
  logic [15:0] m_out;
  logic        m_carry;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ack_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_out   = 16'h0;
    m_carry = 1'b0;
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                            output exp_t e);
    logic [15:0] x, y, w;
    logic [16:0] s;
    logic [3:0]  ra, rb;
    bit          wr;
    ra = a[3:0];
    rb = b[3:0];
    x  = m_regs[ra];
    y  = m_regs[rb];
    w  = 16'h0;
    wr = 1'b0;
    e.jv = 1'b0;
    e.ja = 6'h0;
    case (op)
      4'hF: begin w = {10'h0, b}; wr = 1'b1; end
      4'hD: begin s = {1'b0, x} + {1'b0, y}; w = s[15:0]; m_carry = s[16]; wr = 1'b1; end
      4'hC: begin w = x - y; m_carry = (x < y); wr = 1'b1; end
      4'h8: begin w = x & y; wr = 1'b1; end
      4'h7: begin w = x | y; wr = 1'b1; end
      4'h6: begin w = x ^ y; wr = 1'b1; end
      4'hB: m_out = x;
      4'h9: begin e.jv = 1'b1; e.ja = b; end
      4'h5: if (x == 16'h0) begin e.jv = 1'b1; e.ja = b; end
      default: ;
    endcase
    if (wr && ra != 4'h0) m_regs[ra] = w;
    e.out   = m_out;
    e.carry = m_carry;
  endtask

  // Offer one instruction, wait for its ack, then score the EXEC-edge results.
  task automatic run_inst(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                          input string tag);
    exp_t e;
    bit   got;
    @(negedge clk);
    bus.i_opcode     = op;
    bus.i_operand1   = a;
    bus.i_operand2   = b;
    bus.i_inst_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_inst_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ack: not seen within 4 cycles, required 1", tag);
      bus.i_inst_valid = 1'b0;
      return;
    end
    ack_cyc = cyc;
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_ack: got %b, required 1", tag, bus.o_busy);
    end
    // Scramble the bus so only the latched copy can produce the right answer.
    bus.i_inst_valid = 1'b0;
    bus.i_opcode     = 4'hD;
    bus.i_operand1   = 6'($urandom);
    bus.i_operand2   = 6'($urandom);
    model_exec(op, a, b, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if ({bus.o_out, bus.o_carry, bus.o_jump_valid, bus.o_flush, bus.o_inst_ack, bus.o_busy}
        !== {e.out, e.carry, e.jv, e.jv, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s result: got out=%h c=%b jv=%b fl=%b ack=%b busy=%b, required out=%h c=%b jv=%b fl=%b ack=0 busy=0",
               tag, bus.o_out, bus.o_carry, bus.o_jump_valid, bus.o_flush, bus.o_inst_ack,
               bus.o_busy, e.out, e.carry, e.jv, e.jv);
    end
    if (e.jv) begin
      checks++;
      if (bus.o_jump_addr !== e.ja) begin
        errors++;
        $display("FAIL %s jump_addr: got %h, required %h", tag, bus.o_jump_addr, e.ja);
      end
    end
    $display("[%0t] %s op=%h a=%0d b=%0d -> out=%h carry=%b jv=%b ja=%h", $time, tag, op, a, b,
             bus.o_out, bus.o_carry, bus.o_jump_valid, bus.o_jump_addr);
  endtask

  task automatic test_reset();
    bus.i_flush = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_inst_ack, bus.o_busy, bus.o_jump_valid, bus.o_jump_addr, bus.o_out, bus.o_carry}
        !== 25'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b busy=%b jv=%b ja=%h out=%h c=%b, required all 0",
               bus.o_inst_ack, bus.o_busy, bus.o_jump_valid, bus.o_jump_addr, bus.o_out, bus.o_carry);
    end
    checks++;
    if (bus.o_flush !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush_hi: got %b, required 1", bus.o_flush);
    end
    bus.i_flush = 1'b0;
    #1;
    checks++;
    if (bus.o_flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush_lo: got %b, required 0", bus.o_flush);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    $display("[%0t] reset released", $time);
  endtask

  task automatic test_basic();
    int prev;
    run_inst(OP_LD, 6'd1, 6'd5, "ld_r1_5");
    prev = ack_cyc;
    run_inst(OP_LD, 6'd2, 6'd7, "ld_r2_7");
    checks++;
    if (ack_cyc - prev != 2) begin
      errors++;
      $display("FAIL ack_spacing_1: got %0d cycles, required 2", ack_cyc - prev);
    end
    prev = ack_cyc;
    run_inst(OP_ADD, 6'd1, 6'd2, "add_r1_r2");
    checks++;
    if (ack_cyc - prev != 2) begin
      errors++;
      $display("FAIL ack_spacing_2: got %0d cycles, required 2", ack_cyc - prev);
    end
    run_inst(OP_OUT, 6'd1, 6'd0, "out_r1");
    checks++;
    if (bus.o_out !== 16'd12 || bus.o_carry !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: got out=%0d c=%b, required out=12 c=0", bus.o_out, bus.o_carry);
    end
  endtask

  task automatic test_wrap();
    run_inst(OP_LD, 6'd1, 6'h3F, "ld_r1_3f");
    run_inst(OP_LD, 6'd2, 6'd1, "ld_r2_1");
    for (int i = 0; i < 10; i++) begin
      run_inst(OP_ADD, 6'd1, 6'd1, "add_r1_r1");
      run_inst(OP_ADD, 6'd1, 6'd2, "add_r1_r2");
    end
    run_inst(OP_OUT, 6'd1, 6'd0, "out_ffff");
    checks++;
    if (bus.o_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_build: got %h, required ffff", bus.o_out);
    end
    run_inst(OP_ADD, 6'd1, 6'd2, "add_wrap");
    run_inst(OP_OUT, 6'd1, 6'd0, "out_wrap");
    checks++;
    if (bus.o_out !== 16'h0000 || bus.o_carry !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: got out=%h c=%b, required out=0000 c=1", bus.o_out, bus.o_carry);
    end
    run_inst(OP_SUB, 6'd1, 6'd2, "sub_borrow");
    run_inst(OP_OUT, 6'd1, 6'd0, "out_borrow");
    checks++;
    if (bus.o_out !== 16'hFFFF || bus.o_carry !== 1'b1) begin
      errors++;
      $display("FAIL sub_borrow: got out=%h c=%b, required out=ffff c=1", bus.o_out, bus.o_carry);
    end
    run_inst(OP_SUB, 6'd1, 6'd2, "sub_noborrow");
    run_inst(OP_OUT, 6'd1, 6'd0, "out_noborrow");
  endtask

  task automatic test_logic();
    logic [3:0] ops [6];
    ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_XOR;
    ops[3] = OP_ADD; ops[4] = OP_SUB; ops[5] = 4'h3;
    for (int i = 0; i < 12; i++) begin
      run_inst(OP_LD, 6'd6, 6'($urandom), "ld_r6");
      run_inst(OP_LD, 6'd7, 6'($urandom), "ld_r7");
      run_inst(ops[i % 6], 6'd6, 6'd7, "alu_r6_r7");
      run_inst(OP_OUT, 6'd6, 6'd0, "out_r6");
    end
  endtask

  task automatic test_jump();
    run_inst(OP_JMP, 6'd0, 6'h2A, "jmp_2a");
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_jump_valid !== 1'b0 || bus.o_flush !== 1'b0) begin
      errors++;
      $display("FAIL jmp_one_cycle: got jv=%b fl=%b, required 0 0", bus.o_jump_valid, bus.o_flush);
    end
    run_inst(OP_LD, 6'd3, 6'd4, "ld_r3_4");
    run_inst(OP_JZ, 6'd3, 6'h10, "jz_r3_untaken");
    run_inst(OP_JZ, 6'd0, 6'h15, "jz_r0_taken");
    run_inst(OP_JZ, 6'd9, 6'h3C, "jz_r9_taken");
  endtask

  task automatic test_flush();
    logic [15:0] out_before;
    bit          got;
    out_before = bus.o_out;
    @(negedge clk);
    bus.i_opcode     = OP_LD;
    bus.i_operand1   = 6'd4;
    bus.i_operand2   = 6'd9;
    bus.i_inst_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_inst_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL flush_accept: ack not seen within 4 cycles, required 1");
    end
    bus.i_inst_valid = 1'b0;
    bus.i_flush      = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.o_inst_ack, bus.o_busy, bus.o_jump_valid, bus.o_flush} !== 4'b0001
        || bus.o_out !== out_before) begin
      errors++;
      $display("FAIL flush_exec: got ack=%b busy=%b jv=%b fl=%b out=%h, required 0 0 0 1 out=%h",
               bus.o_inst_ack, bus.o_busy, bus.o_jump_valid, bus.o_flush, bus.o_out, out_before);
    end
    $display("[%0t] flush on EXEC edge -> ack=%b busy=%b", $time, bus.o_inst_ack, bus.o_busy);
    bus.i_flush = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got busy=%b, required 0", bus.o_busy);
    end
    run_inst(OP_OUT, 6'd4, 6'd0, "out_r4_after_flush");
    // Flush and valid in the same cycle: nothing may be accepted.
    @(negedge clk);
    bus.i_opcode     = OP_LD;
    bus.i_operand1   = 6'd5;
    bus.i_operand2   = 6'd1;
    bus.i_inst_valid = 1'b1;
    bus.i_flush      = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_inst_ack !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_wins: got ack=%b busy=%b, required 0 0", bus.o_inst_ack, bus.o_busy);
    end
    $display("[%0t] flush+valid -> ack=%b busy=%b", $time, bus.o_inst_ack, bus.o_busy);
    bus.i_inst_valid = 1'b0;
    bus.i_flush      = 1'b0;
    run_inst(OP_OUT, 6'd5, 6'd0, "out_r5_after_flush");
  endtask

  task automatic test_r0_and_reset_mid();
    bit got;
    run_inst(OP_LD, 6'd0, 6'd3, "ld_r0_3");
    run_inst(OP_OUT, 6'd0, 6'd0, "out_r0");
    checks++;
    if (bus.o_out !== 16'h0) begin
      errors++;
      $display("FAIL r0_zero: got %h, required 0000", bus.o_out);
    end
    run_inst(OP_LD, 6'd1, 6'h3F, "ld_r1_3f");
    run_inst(OP_OUT, 6'd1, 6'd0, "out_r1_pre");
    run_inst(OP_SUB, 6'd0, 6'd1, "sub_set_carry");
    @(negedge clk);
    bus.i_opcode     = OP_JMP;
    bus.i_operand1   = 6'd0;
    bus.i_operand2   = 6'h11;
    bus.i_inst_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_inst_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_inst_ack, bus.o_busy, bus.o_jump_valid, bus.o_jump_addr, bus.o_out, bus.o_carry,
         bus.o_flush} !== 26'h0) begin
      errors++;
      $display("FAIL reset_mid: got ack=%b busy=%b jv=%b ja=%h out=%h c=%b fl=%b, required all 0",
               bus.o_inst_ack, bus.o_busy, bus.o_jump_valid, bus.o_jump_addr, bus.o_out,
               bus.o_carry, bus.o_flush);
    end
    $display("[%0t] reset mid-EXEC -> out=%h busy=%b", $time, bus.o_out, bus.o_busy);
    model_clear();
    @(negedge clk);
    rst_n            = 1'b1;
    bus.i_opcode     = OP_OUT;
    bus.i_operand1   = 6'd1;
    bus.i_operand2   = 6'd0;
    bus.i_inst_valid = 1'b1;
    @(posedge clk);
    #1;
    got = (bus.o_inst_ack === 1'b1);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL first_accept: got ack=%b, required 1", bus.o_inst_ack);
    end
    bus.i_inst_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("[%0t] first accept after reset ack=%b out=%h", $time, got, bus.o_out);
    for (int r = 1; r < 16; r++) run_inst(OP_OUT, 6'(r), 6'd0, "out_after_reset");
  endtask

  initial begin
    bus.i_flush      = 1'b0;
    bus.i_opcode     = 4'h0;
    bus.i_operand1   = 6'h0;
    bus.i_operand2   = 6'h0;
    bus.i_inst_valid = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_wrap();
    test_logic();
    test_jump();
    test_flush();
    test_r0_and_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter WORD_WIDTH, default 16, data word and register width.
REQ-002 Parameter REG_ADDR_WIDTH, default 4, register index width; register count is 2**REG_ADDR_WIDTH.
REQ-003 Parameter OPERAND_WIDTH, default 6, operand field width; SHALL be >= REG_ADDR_WIDTH.
REQ-004 One clock; reset is asynchronous and active-low: i_clk input 1 rising-edge clock; i_rst_n input 1 async active-low reset.
REQ-005 i_flush input 1: synchronous pipeline flush request.
REQ-006 i_opcode input 4, i_operand1 input OPERAND_WIDTH, i_operand2 input OPERAND_WIDTH: offered instruction.
REQ-007 i_inst_valid input 1: instruction offered.
REQ-008 o_inst_ack output 1: one-cycle pulse, instruction accepted.
REQ-009 o_busy output 1: high while an instruction is latched.
REQ-010 o_flush output 1: i_flush OR the registered jump pulse.
REQ-011 o_jump_valid output 1, o_jump_addr output OPERAND_WIDTH: taken-branch pulse and target.
REQ-012 o_out output WORD_WIDTH, o_carry output 1: OUT port register and carry/borrow flag.

Function
REQ-013 FSM states IDLE, EXEC; IDLE with i_inst_valid=1 and i_flush=0 at edge k -> latch opcode and operands, go to EXEC, o_inst_ack=1 for one cycle.
REQ-014 In EXEC, the edge after acceptance executes the latched copy (never the live inputs) and returns to IDLE; throughput is one instruction per two cycles.
REQ-015 o_busy = (state == EXEC); no acceptance in EXEC, the offered instruction is held by the producer.
REQ-016 Register index = low REG_ADDR_WIDTH bits of an operand; r0 reads 0 and writes to r0 are discarded.
REQ-017 Opcodes: F LD rx,imm (rx = zero-extended operand2); D ADD rx,ry; C SUB rx,ry; 8 AND; 7 OR; 6 XOR (all rx = rx op ry); B OUT rx (o_out = rx); 9 JMP imm; 5 JZ rx,imm (jump if rx==0); all others NOP.
REQ-018 Arithmetic wraps modulo 2**WORD_WIDTH; ADD sets o_carry = carry-out; SUB sets o_carry = 1 when rx < ry (unsigned); other opcodes leave o_carry unchanged.
REQ-019 Register writeback takes effect at the EXEC edge; the next instruction reads the new value.
REQ-020 Taken JMP/JZ: o_jump_valid=1 and o_jump_addr=operand2 for exactly one cycle after the EXEC edge; o_flush is high in that same cycle; untaken JZ produces no pulse.
REQ-021 i_flush=1 at any edge: state->IDLE, latched instruction dropped without writeback or jump, o_inst_ack=0; registers, o_out, o_carry are preserved.
REQ-022 i_flush and i_inst_valid together: flush wins, no acceptance.

Reset
REQ-023 i_rst_n low asynchronously forces: state IDLE, o_inst_ack 0, o_busy 0, o_jump_valid 0, o_jump_addr 0, o_out 0, o_carry 0, all registers 0; o_flush then equals i_flush.
REQ-024 Reset mid-EXEC discards the latched instruction; first acceptance is possible at the first rising edge after deassertion.

Structure
REQ-025 Package exec_pkg SHALL hold opcode localparams and the FSM state enum.
REQ-026 Sub-module exec_regfile: two combinational read ports, one synchronous write port, async active-low clear, r0 hardwired zero.

Verification
REQ-027 LD r1,5; LD r2,7; ADD r1,r2; OUT r1 -> o_out=12, o_carry=0; each o_inst_ack spaced two cycles apart.
REQ-028 WORD_WIDTH=16: r1=0xFFFF (via repeated ADDs), r2=1, ADD r1,r2 -> r1=0, o_carry=1; SUB r2 from r1=0 -> r1=0xFFFF, o_carry=1.
REQ-029 JMP 0x2A -> o_jump_valid=1, o_jump_addr=0x2A, o_flush=1 for one cycle; JZ r3,0x10 with r3=4 -> no pulse.
REQ-030 Accept LD r4,9, assert i_flush on the EXEC edge -> r4 stays 0, no ack that cycle, o_busy=0 next cycle.
REQ-031 LD r0,3; OUT r0 -> o_out=0; i_rst_n pulsed low mid-EXEC -> all outputs 0 immediately, r1..rN read 0.
